// File: rtl/adc_threshold_trigger.sv
// Threshold discriminator with hysteresis and holdoff: one fixed-width trigger pulse per crossing.
// Optional missed-crossing counter is enabled by defining MISSED_TRIG_COUNT_EN.
module adc_threshold_trigger #(
  parameter int DATA_W    = 12,
  parameter int HOLDOFF_W = 16,
  parameter int PULSE_LEN = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sample_valid,
  input  logic [DATA_W-1:0]    sample_data,
  input  logic [DATA_W-1:0]    threshold_hi,
  input  logic [DATA_W-1:0]    threshold_lo,
  input  logic [HOLDOFF_W-1:0] holdoff_cycles,
  output logic                 trigger_out,
  output logic                 armed
`ifdef MISSED_TRIG_COUNT_EN
  ,
  output logic [15:0]          missed_count
`endif
);

  localparam int PCNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(PULSE_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REARM,
    ST_ARMED,
    ST_FIRE,
    ST_HOLDOFF
  } state_t;

  state_t               state_reg, state_next;
  logic [PCNT_W-1:0]    pulse_reg, pulse_next;
  logic [HOLDOFF_W-1:0] hold_reg, hold_next;
  logic                 trigger_reg, trigger_next;
  logic                 armed_reg, armed_next;
  logic                 sample_hi, sample_lo;

  assign sample_hi = sample_valid && (sample_data >= threshold_hi);
  assign sample_lo = sample_valid && (sample_data <= threshold_lo);

  always_comb begin
    state_next = state_reg;
    pulse_next = pulse_reg;
    hold_next  = hold_reg;
    if (!enable) begin
      state_next = ST_IDLE;
      pulse_next = '0;
      hold_next  = '0;
    end else begin
      case (state_reg)
        // Always pass through REARM so a level already above hi cannot fire.
        ST_IDLE: state_next = ST_REARM;
        ST_REARM: begin
          if (sample_lo) state_next = ST_ARMED;
        end
        ST_ARMED: begin
          if (sample_hi) begin
            state_next = ST_FIRE;
            pulse_next = PULSE_LAST;
            hold_next  = holdoff_cycles;
          end
        end
        ST_FIRE: begin
          if (pulse_reg == '0) begin
            state_next = (hold_reg == '0) ? ST_REARM : ST_HOLDOFF;
          end else begin
            pulse_next = pulse_reg - PCNT_W'(1);
          end
        end
        ST_HOLDOFF: begin
          if (hold_reg <= HOLDOFF_W'(1)) state_next = ST_REARM;
          if (hold_reg != '0) hold_next = hold_reg - HOLDOFF_W'(1);
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Trigger mirrors FIRE one clock later; dropping enable cuts it on the next edge.
  assign trigger_next = enable && (state_reg == ST_FIRE);
  assign armed_next   = (state_next == ST_ARMED);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      pulse_reg   <= '0;
      hold_reg    <= '0;
      trigger_reg <= 1'b0;
      armed_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pulse_reg   <= pulse_next;
      hold_reg    <= hold_next;
      trigger_reg <= trigger_next;
      armed_reg   <= armed_next;
    end
  end

  assign trigger_out = trigger_reg;
  assign armed       = armed_reg;

`ifdef MISSED_TRIG_COUNT_EN
  logic [15:0] missed_reg, missed_next;

  // One count per over-threshold sample while the discriminator is busy.
  always_comb begin
    missed_next = missed_reg;
    if (!enable) begin
      missed_next = '0;
    end else if (sample_hi && ((state_reg == ST_FIRE) || (state_reg == ST_HOLDOFF)) &&
                 (missed_reg != 16'hFFFF)) begin
      missed_next = missed_reg + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) missed_reg <= '0;
    else        missed_reg <= missed_next;
  end

  assign missed_count = missed_reg;
`endif

endmodule

// File: tb/tb_adc_threshold_trigger.sv
// Bench for adc_threshold_trigger: directed vector table, corner sequences and random
// stimulus against a cycle-indexed event model (pulse window and dead time in absolute edges).
module tb_adc_threshold_trigger;

  localparam int DATA_W    = 12;
  localparam int HOLDOFF_W = 16;
  localparam int PULSE_LEN = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 sample_valid;
  logic [DATA_W-1:0]    sample_data;
  logic [DATA_W-1:0]    threshold_hi;
  logic [DATA_W-1:0]    threshold_lo;
  logic [HOLDOFF_W-1:0] holdoff_cycles;
  logic                 trigger_out;
  logic                 armed;
`ifdef MISSED_TRIG_COUNT_EN
  logic [15:0]          missed_count;
`endif

  adc_threshold_trigger #(
    .DATA_W(DATA_W), .HOLDOFF_W(HOLDOFF_W), .PULSE_LEN(PULSE_LEN)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .sample_valid(sample_valid),
    .sample_data(sample_data),
    .threshold_hi(threshold_hi),
    .threshold_lo(threshold_lo),
    .holdoff_cycles(holdoff_cycles),
    .trigger_out(trigger_out),
    .armed(armed)
`ifdef MISSED_TRIG_COUNT_EN
    ,
    .missed_count(missed_count)
`endif
  );

  always #5 clock = ~clock;

  int tests  = 0;
  int failed = 0;

  // Model: 0 = off, 1 = waiting for a low sample, 2 = armed, 3 = busy (pulse + dead time)
  int m_phase;
  int m_k;
  int m_fire;
  int m_end;
  int m_missed;
  logic exp_trig;
  logic exp_arm;

  int rises;
  int high_cycles;
  logic prev_trig;

  typedef struct {
    logic              en;
    logic              v;
    logic [DATA_W-1:0] d;
    logic              trig;
    logic              arm;
  } vec_t;
  vec_t t2[10];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_fire   = -1000;
    m_end    = -1000;
    m_missed = 0;
  endtask

  task automatic model_edge(input logic en, input logic v, input logic [DATA_W-1:0] d);
    logic hi_hit, lo_hit, was_busy;
    m_k++;
    hi_hit   = v && (d >= threshold_hi);
    lo_hit   = v && (d <= threshold_lo);
    was_busy = (m_phase == 3);
    exp_trig = en && was_busy && (m_k >= m_fire + 1) && (m_k <= m_fire + PULSE_LEN);
    if (!en) begin
      m_phase  = 0;
      m_missed = 0;
    end else begin
      case (m_phase)
        0: m_phase = 1;
        1: if (lo_hit) m_phase = 2;
        2: if (hi_hit) begin
             m_phase = 3;
             m_fire  = m_k;
             m_end   = m_k + PULSE_LEN + int'(holdoff_cycles);
           end
        default: begin
          if (hi_hit && m_missed < 65535) m_missed++;
          if (m_k >= m_end) m_phase = 1;
        end
      endcase
    end
    exp_arm = (m_phase == 2);
  endtask

  // One transaction: drive, clock, compare one cycle's outputs against the model.
  task automatic step(input logic en, input logic v, input logic [DATA_W-1:0] d);
    enable       = en;
    sample_valid = v;
    sample_data  = d;
    @(posedge clock);
    model_edge(en, v, d);
    #1;
    if (trigger_out && !prev_trig) rises++;
    if (trigger_out) high_cycles++;
    prev_trig = trigger_out;
    check("trig_vs_model", trigger_out, exp_trig);
    check("armed_vs_model", armed, exp_arm);
`ifdef MISSED_TRIG_COUNT_EN
    check("missed_vs_model", missed_count, m_missed);
`endif
  endtask

  task automatic async_reset_pulse();
    #2 reset = 1'b0;
    #1;
    check("async_rst_trig", trigger_out, 0);
    check("async_rst_armed", armed, 0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    prev_trig = 1'b0;
  endtask

  initial begin
    int r0, h0;
`ifdef MISSED_TRIG_COUNT_EN
    int m0;
`endif
    t2[0] = '{1'b1, 1'b1, 12'd0,    1'b0, 1'b0};
    t2[1] = '{1'b1, 1'b1, 12'd0,    1'b0, 1'b1};
    t2[2] = '{1'b1, 1'b1, 12'd0,    1'b0, 1'b1};
    t2[3] = '{1'b1, 1'b1, 12'd2500, 1'b0, 1'b0};
    t2[4] = '{1'b1, 1'b1, 12'd2500, 1'b1, 1'b0};
    t2[5] = '{1'b1, 1'b1, 12'd2500, 1'b1, 1'b0};
    t2[6] = '{1'b1, 1'b1, 12'd2500, 1'b1, 1'b0};
    t2[7] = '{1'b1, 1'b1, 12'd2500, 1'b1, 1'b0};
    t2[8] = '{1'b1, 1'b1, 12'd2500, 1'b0, 1'b0};
    t2[9] = '{1'b1, 1'b1, 12'd0,    1'b0, 1'b1};

    m_k = 0;
    rises = 0;
    high_cycles = 0;
    prev_trig = 1'b0;
    model_reset();
    enable = 1'b0;
    sample_valid = 1'b0;
    sample_data = '0;
    threshold_hi = 12'd2000;
    threshold_lo = 12'd1000;
    holdoff_cycles = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_trig", trigger_out, 0);
    check("reset_armed", armed, 0);
`ifdef MISSED_TRIG_COUNT_EN
    check("reset_missed", missed_count, 0);
`endif
    @(negedge clock);
    reset = 1'b1;

    // T2: basic crossing with hold 0, table of expected outputs
    for (int i = 0; i < 10; i++) begin
      step(t2[i].en, t2[i].v, t2[i].d);
      check($sformatf("t2_trig[%0d]", i), trigger_out, t2[i].trig);
      check($sformatf("t2_armed[%0d]", i), armed, t2[i].arm);
    end

    // T1: async reset mid-pulse, then a level above lo must not arm
    step(1, 1, 12'd2500);
    step(1, 1, 12'd2500);
    check("t1_pulse_started", trigger_out, 1);
    async_reset_pulse();
    threshold_lo = 12'd50;
    r0 = rises;
    repeat (4) step(1, 1, 12'd100);
    repeat (3) step(1, 1, 12'd2500);
    check("t1_no_pulse_above_lo", rises - r0, 0);
    step(1, 1, 12'd40);
    step(1, 1, 12'd2500);
    repeat (6) step(1, 1, 12'd0);
    check("t1_pulse_after_rearm", rises - r0, 1);

    // T3: oscillation inside the hysteresis band fires once
    threshold_lo = 12'd1000;
    r0 = rises;
    h0 = high_cycles;
    for (int i = 0; i < 12; i++) step(1, 1, (i % 2) ? 12'd2100 : 12'd1900);
    check("t3_single_pulse", rises - r0, 1);
    check("t3_pulse_width", high_cycles - h0, PULSE_LEN);
    step(1, 1, 12'd900);
    step(1, 1, 12'd2100);
    repeat (6) step(1, 1, 12'd1900);
    check("t3_second_pulse", rises - r0, 2);

    // T4: second crossing inside holdoff is ignored
    holdoff_cycles = 16'd10;
    step(1, 1, 12'd900);
    r0 = rises;
`ifdef MISSED_TRIG_COUNT_EN
    m0 = missed_count;
`endif
    step(1, 1, 12'd2500);
    repeat (4) step(1, 1, 12'd500);
    repeat (5) step(1, 1, 12'd500);
    step(1, 1, 12'd2500);
    check("t4_no_pulse_in_holdoff", rises - r0, 1);
`ifdef MISSED_TRIG_COUNT_EN
    check("t4_missed_inc", missed_count - m0, 1);
`endif
    repeat (10) step(1, 1, 12'd500);
    check("t4_rearmed", armed, 1);

    // T5: enable dropped two clocks into the pulse
    holdoff_cycles = '0;
    r0 = rises;
    h0 = high_cycles;
    step(1, 1, 12'd2500);
    step(1, 1, 12'd2500);
    step(1, 1, 12'd2500);
    step(0, 1, 12'd2500);
    check("t5_truncated_width", high_cycles - h0, 2);
    check("t5_armed_idle", armed, 0);
`ifdef MISSED_TRIG_COUNT_EN
    check("t5_missed_cleared", missed_count, 0);
`endif
    repeat (5) step(1, 1, 12'd3000);
    check("t5_no_fire_reenable", rises - r0, 1);
    step(1, 1, 12'd500);
    step(1, 1, 12'd3000);
    repeat (5) step(1, 1, 12'd0);
    check("t5_fire_after_low", rises - r0, 2);

    // T6: five separated crossings seen as five rising edges downstream
    holdoff_cycles = 16'd3;
    r0 = rises;
    for (int e = 0; e < 5; e++) begin
      repeat (2) step(1, 1, 12'd500);
      step(1, 1, 12'd2500);
      repeat (9) step(1, 1, 12'd2500);
    end
    check("t6_event_count", rises - r0, 5);

    // Random stimulus, including hi==lo and lo>hi configurations
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        case ($urandom_range(0, 3))
          0: begin
            threshold_hi = 12'($urandom_range(2000, 2400));
            threshold_lo = threshold_hi;
          end
          1: begin
            threshold_hi = 12'($urandom_range(1000, 1500));
            threshold_lo = 12'($urandom_range(1600, 2200));
          end
          default: begin
            threshold_hi = 12'($urandom_range(1800, 3000));
            threshold_lo = 12'($urandom_range(500, 1700));
          end
        endcase
        holdoff_cycles = 16'($urandom_range(0, 6));
      end
      if (i % 700 == 350) async_reset_pulse();
      step(($urandom % 32) != 0, ($urandom % 4) != 0, 12'($urandom_range(0, 4095)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
